// File: rtl/dmem_arbiter_if.sv
// Signal bundle between dmem_arbiter, its two requesters (cpu_*, dbg_*) and data_memory (mem_*).
interface dmem_arbiter_if #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_DATA_WIDTH = 32
);
    logic                       cpu_req;
    logic                       cpu_we;
    logic [1:0]                 cpu_rw_mode;
    logic [DMEM_ADDR_WIDTH-1:0] cpu_addr;
    logic [DMEM_DATA_WIDTH-1:0] cpu_wdata;
    logic                       cpu_gnt;
    logic                       cpu_rvalid;
    logic [DMEM_DATA_WIDTH-1:0] cpu_rdata;
    logic                       cpu_err;

    logic                       dbg_req;
    logic                       dbg_we;
    logic [1:0]                 dbg_rw_mode;
    logic [DMEM_ADDR_WIDTH-1:0] dbg_addr;
    logic [DMEM_DATA_WIDTH-1:0] dbg_wdata;
    logic                       dbg_gnt;
    logic                       dbg_rvalid;
    logic [DMEM_DATA_WIDTH-1:0] dbg_rdata;
    logic                       dbg_err;
    logic                       dbg_lock;

    logic                       mem_wr_en;
    logic [1:0]                 mem_rw_mode;
    logic [DMEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DMEM_DATA_WIDTH-1:0] mem_w_data;
    logic [DMEM_DATA_WIDTH-1:0] mem_r_data;

    // Handshake: a requester holds req and its fields stable until it sees gnt high in
    // the same cycle (gnt is combinational); rvalid/err are registered one-cycle pulses.
    modport slave (
        input  cpu_req, cpu_we, cpu_rw_mode, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        input  dbg_req, dbg_we, dbg_rw_mode, dbg_addr, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        output mem_wr_en, mem_rw_mode, mem_addr, mem_w_data,
        input  mem_r_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_rw_mode, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        output dbg_req, dbg_we, dbg_rw_mode, dbg_addr, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
        input  mem_wr_en, mem_rw_mode, mem_addr, mem_w_data,
        output mem_r_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data_memory port between the CPU and debug requesters.
// Optional debug bus lock is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic { OWN_CPU = 1'b0, OWN_DBG = 1'b1 } owner_e;

    owner_e                     last_owner;
    logic                       cpu_win;
    logic                       dbg_win;
    logic                       any_win;
    logic                       issue;
    logic                       cpu_blocked;
    logic                       cpu_legal;
    logic                       dbg_legal;
    logic                       win_legal;
    logic                       win_we;
    logic [1:0]                 win_mode;
    logic [DMEM_ADDR_WIDTH-1:0] win_addr;
    logic [DMEM_DATA_WIDTH-1:0] win_wdata;

    logic [1:0]                 mode_q;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q;
    logic [DMEM_DATA_WIDTH-1:0] wdata_q;

    logic                       cpu_rvalid_q;
    logic                       cpu_err_q;
    logic [DMEM_DATA_WIDTH-1:0] cpu_rdata_q;
    logic                       dbg_rvalid_q;
    logic                       dbg_err_q;
    logic [DMEM_DATA_WIDTH-1:0] dbg_rdata_q;

    function automatic logic access_legal(input logic [1:0] mode, input logic [1:0] lsb);
        logic ok;
        case (mode)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lsb[0];
            2'b10:   ok = (lsb == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign cpu_legal = access_legal(bus.cpu_rw_mode, bus.cpu_addr[1:0]);
    assign dbg_legal = access_legal(bus.dbg_rw_mode, bus.dbg_addr[1:0]);

`ifdef DMEM_ARB_LOCK_EN
    logic lock_active;

    // Armed only by an actual dbg grant with dbg_lock high, so a lock raised while the
    // CPU was last served waits for dbg's next round-robin win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_active <= 1'b0;
        end else begin
            lock_active <= dbg_win && bus.dbg_lock;
        end
    end

    assign cpu_blocked = lock_active && bus.dbg_req && bus.dbg_lock;
`else
    logic unused_lock;
    assign unused_lock = bus.dbg_lock;
    assign cpu_blocked = 1'b0;
`endif

    // Grants are gated by rst so nothing is accepted or written while reset is held.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (rst) begin
            if (bus.cpu_req && !cpu_blocked && (!bus.dbg_req || last_owner == OWN_DBG)) begin
                cpu_win = 1'b1;
            end else if (bus.dbg_req) begin
                dbg_win = 1'b1;
            end
        end
    end

    always_comb begin
        win_we    = bus.dbg_we;
        win_mode  = bus.dbg_rw_mode;
        win_addr  = bus.dbg_addr;
        win_wdata = bus.dbg_wdata;
        win_legal = dbg_legal;
        if (cpu_win) begin
            win_we    = bus.cpu_we;
            win_mode  = bus.cpu_rw_mode;
            win_addr  = bus.cpu_addr;
            win_wdata = bus.cpu_wdata;
            win_legal = cpu_legal;
        end
    end

    assign any_win = cpu_win || dbg_win;
    assign issue   = any_win && win_legal;

    assign bus.cpu_gnt     = cpu_win;
    assign bus.dbg_gnt     = dbg_win;
    assign bus.mem_wr_en   = issue && win_we;
    assign bus.mem_rw_mode = issue ? win_mode  : mode_q;
    assign bus.mem_addr    = issue ? win_addr  : addr_q;
    assign bus.mem_w_data  = issue ? win_wdata : wdata_q;

    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_err    = dbg_err_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

    // data_memory presents read data for the address issued this cycle; it is captured
    // at the closing edge so the owner sees rvalid/rdata in the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner   <= OWN_DBG;
            mode_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            if (any_win) begin
                last_owner <= cpu_win ? OWN_CPU : OWN_DBG;
            end
            if (issue) begin
                mode_q  <= win_mode;
                addr_q  <= win_addr;
                wdata_q <= win_wdata;
            end
            cpu_rvalid_q <= issue && !win_we && cpu_win;
            dbg_rvalid_q <= issue && !win_we && dbg_win;
            cpu_err_q    <= cpu_win && !win_legal;
            dbg_err_q    <= dbg_win && !win_legal;
            if (issue && !win_we && cpu_win) begin
                cpu_rdata_q <= bus.mem_r_data;
            end
            if (issue && !win_we && dbg_win) begin
                dbg_rdata_q <= bus.mem_r_data;
            end
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory port between two requesters: the CPU load/store path (cpu_*) and a debug/loader port (dbg_*).
- Arbitrates round-robin on conflict and issues at most one access per cycle to memory.
- Routes read data back to the requester that issued the read, one cycle later.
- Rejects misaligned or reserved-mode accesses without touching memory.

Parameters:
- DMEM_ADDR_WIDTH, 12, byte-address width on all ports.
- DMEM_DATA_WIDTH, 32, data width on all ports.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- cpu_req  in  1  CPU access request, held until cpu_gnt.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_rw_mode  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- cpu_addr  in  DMEM_ADDR_WIDTH  byte address.
- cpu_wdata  in  DMEM_DATA_WIDTH  store data.
- cpu_gnt  out  1  access accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu_rdata valid (registered).
- cpu_rdata  out  DMEM_DATA_WIDTH  load data.
- cpu_err  out  1  one-cycle error pulse, registered.
- dbg_req, dbg_we, dbg_rw_mode, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: same as the cpu_* set, for the debug port.
- dbg_lock  in  1  see Optional Feature.
- mem_wr_en  out  1  to data_memory wr_en.
- mem_rw_mode  out  2  to data_memory rw_mode.
- mem_addr  out  DMEM_ADDR_WIDTH  to data_memory addr.
- mem_w_data  out  DMEM_DATA_WIDTH  to data_memory w_data.
- mem_r_data  in  DMEM_DATA_WIDTH  from data_memory r_data; sampled one cycle after address issue.

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt, rvalid and err outputs all 0.
  - rdata outputs 0.
  - last_owner = DBG, so the CPU wins the first tie.
  - rd_pending cleared; no stale rvalid after reset release.
- Arbitration, per cycle, combinational on req and last_owner:
  - Only one req high: that requester is granted.
  - Both high: grant the requester not equal to last_owner.
  - last_owner updates on every grant, including errored grants.
- Memory drive:
  - When the winning access is legal, mem_addr, mem_rw_mode and mem_w_data are driven from the winner.
  - mem_wr_en = winner_we.
  - With no grant: mem_wr_en = 0; mem_addr, mem_rw_mode and mem_w_data hold their previous driven values (no toggling).
- Legality check:
  - Illegal: rw_mode = 11; half with addr[0]=1; word with addr[1:0]!=00.
  - An illegal request is still granted (gnt=1) so the requester can drop it.
  - No memory access is made: mem_wr_en = 0.
  - Next cycle: err=1 to that requester, no rvalid.
- Read response:
  - A legal granted load sets rd_pending and rd_owner.
  - Next cycle: owner's rvalid=1 and owner's rdata = mem_r_data (registered).
  - The other requester's rdata holds its value.
- Stores: no response pulse; gnt is the only completion.
- Throughput: one access per cycle. Back-to-back loads from alternating owners give back-to-back rvalid with the correct owner per cycle.
- req dropped without gnt: no effect and no state change.
- Simultaneous load response for cycle N and new grant in cycle N+1 are independent; both allowed.
- Reset asserted mid-access:
  - Pending response discarded.
  - Memory write in flight suppressed from the reset edge on (mem_wr_en forced 0 while rst=0).

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined:
  - dbg_lock=1 while dbg owns the last grant makes dbg sticky: CPU is not granted while dbg_req=1 and dbg_lock=1.
  - Lock releases when dbg_lock=0 or dbg_req=0 for a cycle.
  - A lock request while the CPU is last_owner takes effect only after dbg's next normal round-robin grant.
- Undefined: dbg_lock ignored; pure round-robin.

Test Plan:
- Reset, then cpu_req load, word mode, addr 0x010, mem returns 0xDEADBEEF → cpu_gnt=1 in the same cycle; next cycle cpu_rvalid=1 with cpu_rdata=0xDEADBEEF; dbg_rvalid=0.
- cpu_req and dbg_req both held for 4 cycles, both loads → grants CPU, DBG, CPU, DBG; rvalid alternates to match, one cycle later each.
- dbg store, word, addr 0x020, data 0x12345678 → mem_wr_en=1, mem_addr=0x020, mem_w_data=0x12345678 for exactly 1 cycle; no rvalid.
- cpu load, word, addr 0x002, then half at 0x003, then rw_mode 11 → each granted; mem_wr_en=0; cpu_err pulses the next cycle; no cpu_rvalid.
- rst driven low one cycle after a cpu load grant → cpu_rvalid stays 0; after release, first tie goes to the CPU.
- DMEM_ARB_LOCK_EN: dbg granted with dbg_lock=1, both req held 3 cycles → dbg granted 3 times; dbg_lock=0 → CPU granted next cycle.
